// File: rtl/dmem_banked_if.sv
// dmem_banked_if: valid/ready request and 1-cycle response bus; master drives requests, slave answers
interface dmem_banked_if #(parameter int DATA_W = 32);
  localparam int NB = DATA_W / 8;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [31:0]       req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [NB-1:0]     req_be;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  modport master (output req_valid, req_we, req_addr, req_wdata, req_be,
                  input  req_ready, rsp_valid, rsp_rdata, rsp_err);
  modport slave  (input  req_valid, req_we, req_addr, req_wdata, req_be,
                  output req_ready, rsp_valid, rsp_rdata, rsp_err);
endinterface

// File: rtl/dmem_banked.sv
// dmem_banked: byte-enabled word RAM in a base window with 1-cycle registered response and clear sequencer; ports clk, reset (async active-low), clr, bus (slave), busy
module dmem_banked #(
  parameter int          ADDR_BITS = 12,
  parameter int          DATA_W    = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clr,
  dmem_banked_if.slave   bus,
  output logic           busy
);
  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam int NB    = DATA_W / 8;
  localparam int OFFB  = $clog2(NB);
  typedef enum logic {CLEAR, IDLE} state_t;
  state_t                state, state_n;
  logic [ADDR_BITS-1:0]  cnt, cnt_n, idx;
  logic [DATA_W-1:0]     mem [DEPTH];
  logic [31:0]           off;
  logic                  in_range, acc;
  assign off           = bus.req_addr - BASE_ADDR;
  assign in_range      = (off >> (OFFB + ADDR_BITS)) == 32'd0;
  assign idx           = off[OFFB +: ADDR_BITS];
  assign busy          = state == CLEAR;
  assign bus.req_ready = state == IDLE && !clr;
  assign acc           = bus.req_valid && bus.req_ready;
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (clr) begin
      state_n = CLEAR;
      cnt_n   = '0;
    end else if (state == CLEAR) begin
      cnt_n   = cnt + 1'b1;
      state_n = cnt == ADDR_BITS'(DEPTH - 1) ? IDLE : CLEAR;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= CLEAR;
      cnt           <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_rdata <= '0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      bus.rsp_valid <= acc;
      bus.rsp_err   <= acc && !in_range;
      bus.rsp_rdata <= acc && !bus.req_we && in_range ? mem[idx] : '0;
    end
  end
  always_ff @(posedge clk) begin
    if (state == CLEAR)
      mem[cnt] <= '0;
    else if (acc && bus.req_we && in_range)
      for (int k = 0; k < NB; k++)
        if (bus.req_be[k]) mem[idx][8*k +: 8] <= bus.req_wdata[8*k +: 8];
  end
endmodule

// File: tb/tb_dmem_banked.sv
// tb_dmem_banked: scoreboard bench for dmem_banked at default and 64-bit/16-word/0x1000 configurations
module tb_dmem_banked;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst0 = 1'b0, rst1 = 1'b0, clr0 = 1'b0, clr1 = 1'b0;
  logic busy0, busy1;
  dmem_banked_if #(.DATA_W(32)) a0 ();
  dmem_banked_if #(.DATA_W(64)) a1 ();
  dmem_banked u0 (.clk(clk), .reset(rst0), .clr(clr0), .bus(a0.slave), .busy(busy0));
  dmem_banked #(.ADDR_BITS(4), .DATA_W(64), .BASE_ADDR(32'h1000))
    u1 (.clk(clk), .reset(rst1), .clr(clr1), .bus(a1.slave), .busy(busy1));
  typedef struct {logic [63:0] d; logic e; int c;} exp_t;
  exp_t q0[$], q1[$];
  exp_t e0, e1;
  int tests = 0, fails = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", n, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (q0.size() != 0 && q0[0].c == cyc) begin
      e0 = q0.pop_front();
      chk("rsp0_valid", 64'(a0.rsp_valid), 64'd1);
      if (a0.rsp_valid) begin
        chk("rsp0_rdata", 64'(a0.rsp_rdata), e0.d);
        chk("rsp0_err", 64'(a0.rsp_err), 64'(e0.e));
      end
    end else if (a0.rsp_valid) chk("rsp0_spurious", 64'(a0.rsp_valid), 64'd0);
    if (q1.size() != 0 && q1[0].c == cyc) begin
      e1 = q1.pop_front();
      chk("rsp1_valid", 64'(a1.rsp_valid), 64'd1);
      if (a1.rsp_valid) begin
        chk("rsp1_rdata", a1.rsp_rdata, e1.d);
        chk("rsp1_err", 64'(a1.rsp_err), 64'(e1.e));
      end
    end else if (a1.rsp_valid) chk("rsp1_spurious", 64'(a1.rsp_valid), 64'd0);
  end
  task automatic op0(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [3:0] be, input logic [31:0] ed, input logic ee);
    a0.req_valid = 1'b1;
    a0.req_we    = we;
    a0.req_addr  = addr;
    a0.req_wdata = wd;
    a0.req_be    = be;
    chk("ready0", 64'(a0.req_ready), 64'd1);
    q0.push_back('{d: 64'(ed), e: ee, c: cyc + 1});
    @(posedge clk);
    #1 a0.req_valid = 1'b0;
  endtask
  task automatic op1(input logic we, input logic [31:0] addr, input logic [63:0] wd,
                     input logic [7:0] be, input logic [63:0] ed, input logic ee);
    a1.req_valid = 1'b1;
    a1.req_we    = we;
    a1.req_addr  = addr;
    a1.req_wdata = wd;
    a1.req_be    = be;
    chk("ready1", 64'(a1.req_ready), 64'd1);
    q1.push_back('{d: ed, e: ee, c: cyc + 1});
    @(posedge clk);
    #1 a1.req_valid = 1'b0;
  endtask
  task automatic wait0(input string n);
    int k = 0, bad = 0;
    @(negedge clk);
    while (busy0 && k < 5000) begin
      if (a0.req_ready) bad++;
      k++;
      @(negedge clk);
    end
    chk(n, 64'(k), 64'd4096);
    chk({n, "_rdy_busy"}, 64'(bad), 64'd0);
    chk({n, "_rdy_end"}, 64'(a0.req_ready), 64'd1);
  endtask
  task automatic wait1(input string n);
    int k = 0, bad = 0;
    @(negedge clk);
    while (busy1 && k < 100) begin
      if (a1.req_ready) bad++;
      k++;
      @(negedge clk);
    end
    chk(n, 64'(k), 64'd16);
    chk({n, "_rdy_busy"}, 64'(bad), 64'd0);
    chk({n, "_rdy_end"}, 64'(a1.req_ready), 64'd1);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    a0.req_valid = 1'b0; a0.req_we = 1'b0; a0.req_addr = '0; a0.req_wdata = '0; a0.req_be = '0;
    a1.req_valid = 1'b0; a1.req_we = 1'b0; a1.req_addr = '0; a1.req_wdata = '0; a1.req_be = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst0_rsp_valid", 64'(a0.rsp_valid), 64'd0);
    chk("rst0_rsp_rdata", 64'(a0.rsp_rdata), 64'd0);
    chk("rst0_rsp_err", 64'(a0.rsp_err), 64'd0);
    chk("rst0_busy", 64'(busy0), 64'd1);
    chk("rst0_ready", 64'(a0.req_ready), 64'd0);
    @(posedge clk);
    #1 rst0 = 1'b1;
    a0.req_valid = 1'b1;
    a0.req_we    = 1'b0;
    a0.req_addr  = 32'h0;
    wait0("clear0_after_reset");
    q0.push_back('{d: 64'd0, e: 1'b0, c: cyc + 1});
    @(posedge clk);
    #1 a0.req_valid = 1'b0;
    op0(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 32'h0, 1'b0);
    op0(1'b0, 32'h10, 32'h0, 4'b0000, 32'hDEADBEEF, 1'b0);
    op0(1'b1, 32'h10, 32'h0000_5500, 4'b0010, 32'h0, 1'b0);
    op0(1'b0, 32'h10, 32'h0, 4'b0000, 32'hDEAD55EF, 1'b0);
    op0(1'b0, 32'h13, 32'h0, 4'b0000, 32'hDEAD55EF, 1'b0);
    op0(1'b1, 32'h0, 32'h11223344, 4'b1111, 32'h0, 1'b0);
    op0(1'b0, 32'h4000, 32'h0, 4'b0000, 32'h0, 1'b1);
    op0(1'b1, 32'h4000, 32'hFFFFFFFF, 4'b1111, 32'h0, 1'b1);
    op0(1'b1, 32'hFFFFFFFC, 32'hFFFFFFFF, 4'b1111, 32'h0, 1'b1);
    op0(1'b1, 32'h0, 32'hFFFFFFFF, 4'b0000, 32'h0, 1'b0);
    op0(1'b0, 32'h0, 32'h0, 4'b0000, 32'h11223344, 1'b0);
    op0(1'b0, 32'h3FFC, 32'h0, 4'b0000, 32'h0, 1'b0);
    op0(1'b1, 32'h8, 32'hAAAA5555, 4'b1111, 32'h0, 1'b0);
    op0(1'b1, 32'hC, 32'h0BADF00D, 4'b1111, 32'h0, 1'b0);
    op0(1'b0, 32'h8, 32'h0, 4'b0000, 32'hAAAA5555, 1'b0);
    op0(1'b0, 32'hC, 32'h0, 4'b0000, 32'h0BADF00D, 1'b0);
    op0(1'b0, 32'h8, 32'h0, 4'b0000, 32'hAAAA5555, 1'b0);
    op0(1'b1, 32'h0, 32'h12345678, 4'b1111, 32'h0, 1'b0);
    a0.req_valid = 1'b1;
    a0.req_we    = 1'b0;
    a0.req_addr  = 32'h0;
    q0.push_back('{d: 64'h12345678, e: 1'b0, c: cyc + 1});
    @(posedge clk);
    #1 clr0 = 1'b1;
    #1 chk("clr0_blocks_ready", 64'(a0.req_ready), 64'd0);
    @(posedge clk);
    #1 clr0 = 1'b0;
    a0.req_valid = 1'b0;
    wait0("clear0_soft");
    @(posedge clk);
    #1 op0(1'b0, 32'h0, 32'h0, 4'b0000, 32'h0, 1'b0);
    op0(1'b0, 32'h10, 32'h0, 4'b0000, 32'h0, 1'b0);
    clr0 = 1'b1;
    @(posedge clk);
    #1 clr0 = 1'b0;
    repeat (100) @(posedge clk);
    #1 rst0 = 1'b0;
    #1 chk("midclr0_busy", 64'(busy0), 64'd1);
    chk("midclr0_ready", 64'(a0.req_ready), 64'd0);
    @(posedge clk);
    #1 rst0 = 1'b1;
    wait0("clear0_midrst");
    @(posedge clk);
    #1 a0.req_valid = 1'b1;
    a0.req_we   = 1'b0;
    a0.req_addr = 32'h10;
    @(posedge clk);
    #1 chk("owed0_valid", 64'(a0.rsp_valid), 64'd1);
    rst0 = 1'b0;
    a0.req_valid = 1'b0;
    #1 chk("owed0_dropped", 64'(a0.rsp_valid), 64'd0);
    chk("owed0_busy", 64'(busy0), 64'd1);
    @(posedge clk);
    #1 rst0 = 1'b1;
    wait0("clear0_rsprst");
    @(posedge clk);
    #1 op0(1'b0, 32'h0, 32'h0, 4'b0000, 32'h0, 1'b0);
    @(negedge clk);
    chk("rst1_busy", 64'(busy1), 64'd1);
    chk("rst1_ready", 64'(a1.req_ready), 64'd0);
    @(posedge clk);
    #1 rst1 = 1'b1;
    wait1("clear1_after_reset");
    @(posedge clk);
    #1 op1(1'b1, 32'h1008, 64'h0102030405060708, 8'hFF, 64'h0, 1'b0);
    op1(1'b0, 32'h100C, 64'h0, 8'h00, 64'h0102030405060708, 1'b0);
    op1(1'b0, 32'h1000, 64'h0, 8'h00, 64'h0, 1'b0);
    op1(1'b0, 32'h1080, 64'h0, 8'h00, 64'h0, 1'b1);
    op1(1'b0, 32'h0FF8, 64'h0, 8'h00, 64'h0, 1'b1);
    op1(1'b1, 32'h1080, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 64'h0, 1'b1);
    op1(1'b1, 32'h1008, 64'hFFFFFFFFFFFFFFFF, 8'h0F, 64'h0, 1'b0);
    op1(1'b0, 32'h1008, 64'h0, 8'h00, 64'h01020304FFFFFFFF, 1'b0);
    op1(1'b0, 32'h1078, 64'h0, 8'h00, 64'h0, 1'b0);
    clr1 = 1'b1;
    @(posedge clk);
    #1 clr1 = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst1 = 1'b0;
    #1 chk("midclr1_busy", 64'(busy1), 64'd1);
    @(posedge clk);
    #1 rst1 = 1'b1;
    wait1("clear1_midrst");
    @(posedge clk);
    #1 op1(1'b0, 32'h1008, 64'h0, 8'h00, 64'h0, 1'b0);
    repeat (3) @(posedge clk);
    chk("q0_drained", 64'(q0.size()), 64'd0);
    chk("q1_drained", 64'(q1.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
